mux_rr_arbiter: RTL
===================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one BIT_WIDTH datapath between NUM_REQ requesters.
//  Each requester has a valid/ready port; the arbiter owns the mux select and steers the
//  granted lane to a single valid/ready output. Used ahead of shared NFU lanes and buffers.
//  o_data is produced by a mux_16_to_1 instance when NUM_REQ==16, else a generic indexed select.
// PARAMETERS
//  BIT_WIDTH   16   data width per requester
//  NUM_REQ     16   number of requesters (2..16)
//  SEL_WIDTH   4    select width; must equal clog2(NUM_REQ)
// PORTS
//  clk            in   1                  clock, all state on rising edge
//  rst            in   1                  synchronous reset, active-high
//  i_req_valid    in   NUM_REQ            per-requester valid
//  i_req_data     in   BIT_WIDTH*NUM_REQ  packed data, lane k at [k*BIT_WIDTH +: BIT_WIDTH]
//  o_req_ready    out  NUM_REQ            per-requester ready (one-hot or zero)
//  o_valid        out  1                  shared output valid
//  o_data         out  BIT_WIDTH          shared output data = lane o_sel
//  i_ready        in   1                  downstream ready
//  o_sel          out  SEL_WIDTH          current grant index (mux select)
//  o_xfer_count   out  32                 only with MUX_ARB_PERF_EN
// BEHAVIOUR
//  - States: IDLE, GRANT. Registers: state, sel, ptr (next priority start).
//  - Reset: state=IDLE, sel=0, ptr=0, o_valid=0, o_req_ready=0, o_sel=0, count=0.
//  - rst gates o_valid/o_req_ready low combinationally in the rst cycle: no transfer is accepted then.
//  - IDLE: if any i_req_valid, choose first set bit scanning ptr, ptr+1, ... wrap mod NUM_REQ;
//    sel<=winner, state<=GRANT. Grant visible the cycle after request (1-cycle arb latency).
//  - GRANT: o_valid=i_req_valid[sel]; o_data=lane sel; o_req_ready[sel]=i_ready, others 0.
//  - Transfer = GRANT & i_req_valid[sel] & i_ready. On transfer: ptr<=sel+1 (wrap to 0);
//    re-arbitrate same cycle over i_req_valid with bit sel masked, scan from sel+1;
//    winner -> sel<=winner, stay GRANT (back-to-back, 1 beat/cycle); none -> IDLE.
//  - Consequence: lone requester gets 1 beat per 2 cycles; >=2 requesters get full throughput.
//  - Stall (i_ready=0): sel, o_data, o_sel held; no ptr change.
//  - Granted i_req_valid drops in GRANT (protocol violation): no transfer, state<=IDLE next cycle,
//    ptr unchanged; new arbitration from IDLE.
//  - Requesters must hold data stable while valid & !ready; arbiter does not buffer data.
//  - o_sel is registered sel; stable for the whole GRANT tenure.
//  - ptr arithmetic mod NUM_REQ (non-power-of-2 NUM_REQ: sel==NUM_REQ-1 -> ptr=0).
// CONFIGURATION
//  MUX_ARB_PERF_EN defined: o_xfer_count port exists; 32-bit counter +1 per transfer,
//   saturates at 32'hFFFF_FFFF, cleared by rst.
//  MUX_ARB_PERF_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 lone req: i_req_valid=16'h0008 held, i_ready=1 -> o_sel=3, o_valid=1 at c1, c3, c5...; IDLE c2,c4.
//  2 all 16 valid, i_ready=1 -> grants 0,1,...,15,0 one per cycle from c1; o_data tracks lane.
//  3 lane 7 granted, i_ready=0 for 5 cycles -> o_sel=7, o_data stable, o_req_ready=0; then i_ready=1
//    -> o_req_ready=16'h0080 one cycle, transfer.
//  4 wrap: ptr after grant 15 = 0; reqs 2 and 14 -> grant 2 then 14 then back to 2.
//  5 rst high mid-GRANT with i_ready=1 -> no transfer that cycle; next cycle state IDLE,
//    o_valid=0, o_sel=0, ptr=0 (count 0 with MUX_ARB_PERF_EN).
//  6 granted lane drops valid -> o_valid=0, IDLE next cycle, ptr unchanged; PERF_EN count =
//    exact transfer total from tests 1-4.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin valid/ready arbiter steering NUM_REQ lanes onto one shared port
// Optional transfer counter (o_xfer_count) is built only when MUX_ARB_PERF_EN is defined.

module mux_16_to_1 #(
  parameter int BIT_WIDTH = 16
) (
  input  logic [3:0]              i_sel,
  input  logic [16*BIT_WIDTH-1:0] i_data,
  output logic [BIT_WIDTH-1:0]    o_data
);
  logic [BIT_WIDTH-1:0] lanes [16];

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      lanes[k] = i_data[k*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  assign o_data = lanes[i_sel];
endmodule

module mux_rr_arbiter #(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_REQ   = 16,
  parameter int SEL_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [BIT_WIDTH*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic                         o_valid,
  output logic [BIT_WIDTH-1:0]         o_data,
  input  logic                         i_ready,
  output logic [SEL_WIDTH-1:0]         o_sel
`ifdef MUX_ARB_PERF_EN
  ,
  output logic [31:0]                  o_xfer_count
`endif
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]           state;
  logic [SEL_WIDTH-1:0] sel;
  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] sel_plus1;
  logic [SEL_WIDTH-1:0] scan_start;
  logic [SEL_WIDTH-1:0] scan_idx;
  logic [SEL_WIDTH-1:0] winner;
  logic [NUM_REQ-1:0]   sel_onehot;
  logic [NUM_REQ-1:0]   scan_vec;
  logic                 found;
  logic                 granted_valid;
  logic                 in_grant;
  logic                 xfer;

  assign sel_onehot    = NUM_REQ'(1) << sel;
  assign granted_valid = i_req_valid[sel];
  assign in_grant      = !rst && (state == ST_GRANT);
  assign xfer          = in_grant && granted_valid && i_ready;
  assign sel_plus1     = (sel == SEL_WIDTH'(NUM_REQ-1)) ? '0 : sel + SEL_WIDTH'(1);

  // In GRANT the current winner is masked so a second requester can take the next beat.
  always_comb begin
    scan_start = (state == ST_GRANT) ? sel_plus1 : ptr;
    scan_vec   = (state == ST_GRANT) ? (i_req_valid & ~sel_onehot) : i_req_valid;
    found      = 1'b0;
    winner     = '0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = SEL_WIDTH'((int'(scan_start) + i) % NUM_REQ);
      if (!found && scan_vec[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sel   <= '0;
      ptr   <= '0;
    end else if (state == ST_IDLE) begin
      if (found) begin
        sel   <= winner;
        state <= ST_GRANT;
      end
    end else if (!granted_valid) begin
      state <= ST_IDLE;
    end else if (i_ready) begin
      ptr <= sel_plus1;
      if (found) begin
        sel <= winner;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  assign o_valid     = in_grant && granted_valid;
  assign o_req_ready = (in_grant && i_ready) ? sel_onehot : '0;
  assign o_sel       = sel;

  generate
    if (NUM_REQ == 16) begin : g_mux16
      mux_16_to_1 #(.BIT_WIDTH(BIT_WIDTH)) u_mux (
        .i_sel  (sel[3:0]),
        .i_data (i_req_data),
        .o_data (o_data)
      );
    end else begin : g_mux_generic
      assign o_data = i_req_data[int'(sel)*BIT_WIDTH +: BIT_WIDTH];
    end
  endgenerate

`ifdef MUX_ARB_PERF_EN
  logic [31:0] xfer_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (xfer && (xfer_count != 32'hFFFF_FFFF)) begin
      xfer_count <= xfer_count + 32'd1;
    end
  end

  assign o_xfer_count = xfer_count;
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif
endmodule
